// File: rtl/mu0_control.sv
// -----------------------------------------------------------------------------
// mu0_control
//   Control sequencer for the 16-bit MU0 datapath. Runs a fetch/execute FSM
//   against variable-latency memory (mem_ready handshake) and stops the
//   processor with a sticky bus error if an access waits too long.
//
// Ports
//   Clk        in   system clock, rising edge
//   nReset     in   asynchronous active-low reset
//   F[3:0]     in   opcode, IR[15:12]
//   N, Z       in   Acc negative / zero flags
//   mem_ready  in   memory completes the current access this cycle
//   X_sel      out  X mux   (0=PC, 1=Acc)
//   Y_sel      out  Y mux   (0=IR[11:0], 1=memory data)
//   Addr_sel   out  address (0=PC, 1=IR[11:0])
//   ALU_fs     out  00=pass Y, 01=X+Y, 10=X+1, 11=X-Y
//   PC_En, IR_En, Acc_En  out  register load enables
//   MEM_rd, MEM_wr        out  memory strobes
//   Halted     out  processor stopped
//   Bus_err    out  sticky memory-timeout flag
// -----------------------------------------------------------------------------
module mu0_control #(
  parameter int WAIT_LIMIT = 15,
  parameter int WCNT_W     = 8
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       mem_ready,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic [1:0] ALU_fs,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic       MEM_rd,
  output logic       MEM_wr,
  output logic       Halted,
  output logic       Bus_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [WCNT_W-1:0] LIMIT = WCNT_W'(WAIT_LIMIT);

  state_t            r_state;
  state_t            w_next_state;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_bus_err;
  logic              w_mem_access;
  logic              w_waiting;
  logic              w_timeout;

  // A memory access is in flight during every FETCH and during EXEC of
  // opcodes 0-3 (the only ones that touch memory).
  assign w_mem_access = (r_state == S_FETCH) ||
                        ((r_state == S_EXEC) && (F[3:2] == 2'b00));
  assign w_waiting    = w_mem_access && !mem_ready;
  // mem_ready in the limit cycle wins, so timeout needs mem_ready low.
  assign w_timeout    = w_waiting && (r_wait_cnt == LIMIT);

  assign Bus_err = r_bus_err;

  // State register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Wait counter and sticky bus-error flag
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_wait_cnt <= {WCNT_W{1'b0}};
      r_bus_err  <= 1'b0;
    end else begin
      if (w_next_state != r_state) begin
        r_wait_cnt <= {WCNT_W{1'b0}};
      end else if (w_waiting) begin
        r_wait_cnt <= r_wait_cnt + {{(WCNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end else begin
        r_bus_err <= r_bus_err;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          w_next_state = S_EXEC;
        end else if (w_timeout) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_EXEC: begin
        if (w_mem_access) begin
          if (mem_ready) begin
            w_next_state = S_FETCH;
          end else if (w_timeout) begin
            w_next_state = S_HALT;
          end else begin
            w_next_state = S_EXEC;
          end
        end else if (F == OP_STP) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode; enables on memory opcodes are gated by mem_ready so a
  // stalled or timed-out access never loads a register.
  always_comb begin
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    ALU_fs   = 2'b00;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    MEM_rd   = 1'b0;
    MEM_wr   = 1'b0;
    Halted   = 1'b0;
    case (r_state)
      S_IDLE: begin
        Halted = 1'b0;
      end
      S_FETCH: begin
        MEM_rd = 1'b1;
        ALU_fs = 2'b10;
        IR_En  = mem_ready;
        PC_En  = mem_ready;
      end
      S_EXEC: begin
        case (F)
          OP_LDA: begin
            Addr_sel = 1'b1;
            MEM_rd   = 1'b1;
            Y_sel    = 1'b1;
            ALU_fs   = 2'b00;
            Acc_En   = mem_ready;
          end
          OP_STA: begin
            Addr_sel = 1'b1;
            MEM_wr   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Addr_sel = 1'b1;
            MEM_rd   = 1'b1;
            X_sel    = 1'b1;
            Y_sel    = 1'b1;
            ALU_fs   = (F == OP_ADD) ? 2'b01 : 2'b11;
            Acc_En   = mem_ready;
          end
          OP_JMP: begin
            PC_En = 1'b1;
          end
          OP_JGE: begin
            PC_En = !N;
          end
          OP_JNE: begin
            PC_En = !Z;
          end
          OP_STP: begin
            PC_En = 1'b0;
          end
          default: begin
            PC_En = 1'b0;
          end
        endcase
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: begin
        Halted = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mu0_control.sv
module tb_mu0_control;

  logic       Clk;
  logic       nReset;
  logic [3:0] F;
  logic       N;
  logic       Z;
  logic       mem_ready;
  logic       X_sel, Y_sel, Addr_sel;
  logic [1:0] ALU_fs;
  logic       PC_En, IR_En, Acc_En, MEM_rd, MEM_wr, Halted, Bus_err;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_q[$];
  string       name_q[$];

  mu0_control #(.WAIT_LIMIT(15), .WCNT_W(8)) dut (
    .Clk(Clk), .nReset(nReset), .F(F), .N(N), .Z(Z), .mem_ready(mem_ready),
    .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .ALU_fs(ALU_fs),
    .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En), .MEM_rd(MEM_rd),
    .MEM_wr(MEM_wr), .Halted(Halted), .Bus_err(Bus_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Output bundle: {X,Y,Addr,ALU_fs[1:0],PC_En,IR_En,Acc_En,MEM_rd,MEM_wr,Halted,Bus_err}
  function automatic logic [11:0] ev(input logic x, input logic y, input logic a,
                                     input logic [1:0] fs, input logic pc,
                                     input logic ir, input logic acc,
                                     input logic rd, input logic wr,
                                     input logic h, input logic be);
    return {x, y, a, fs, pc, ir, acc, rd, wr, h, be};
  endfunction

  localparam logic [11:0] E_ZERO   = 12'h000;
  logic [11:0] e_f_stall, e_f_ok, e_lda_ok, e_sta, e_add_stall, e_add_ok;
  logic [11:0] e_sub_ok, e_jmp, e_halt, e_halt_be;

  // Scoreboard monitor: compare whenever an expectation is pending.
  always @(negedge Clk) begin
    if (exp_q.size() != 0) begin
      logic [11:0] e;
      logic [11:0] act;
      string       nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {X_sel, Y_sel, Addr_sel, ALU_fs, PC_En, IR_En, Acc_En,
             MEM_rd, MEM_wr, Halted, Bus_err};
      checks = checks + 1;
      if (act !== e) begin
        errors = errors + 1;
        $display("FAIL %s: got %03h expected %03h (t=%0t)", nm, act, e, $time);
      end
    end
  end

  // One clock of stimulus plus its expected combinational response.
  task automatic cyc(input logic rst, input logic [3:0] f, input logic n,
                     input logic z, input logic mr, input logic [11:0] e,
                     input string nm);
    @(posedge Clk);
    #1;
    nReset = rst; F = f; N = n; Z = z; mem_ready = mr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    e_f_stall   = ev(1'b0,1'b0,1'b0,2'b10,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0);
    e_f_ok      = ev(1'b0,1'b0,1'b0,2'b10,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0);
    e_lda_ok    = ev(1'b0,1'b1,1'b1,2'b00,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0);
    e_sta       = ev(1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0);
    e_add_stall = ev(1'b1,1'b1,1'b1,2'b01,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0);
    e_add_ok    = ev(1'b1,1'b1,1'b1,2'b01,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0);
    e_sub_ok    = ev(1'b1,1'b1,1'b1,2'b11,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0);
    e_jmp       = ev(1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0);
    e_halt      = ev(1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0);
    e_halt_be   = ev(1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1);

    nReset = 1'b0; F = 4'h0; N = 1'b0; Z = 1'b0; mem_ready = 1'b1;

    // Program LDA, STA, STP with zero-wait memory
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, E_ZERO,   "reset");
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, E_ZERO,   "idle");
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, e_f_ok,   "fetch_lda");
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, e_lda_ok, "exec_lda");
    cyc(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, e_f_ok,   "fetch_sta");
    cyc(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, e_sta,    "exec_sta");
    cyc(1'b1, 4'h7, 1'b0, 1'b0, 1'b1, e_f_ok,   "fetch_stp");
    cyc(1'b1, 4'h7, 1'b0, 1'b0, 1'b1, E_ZERO,   "exec_stp");
    cyc(1'b1, 4'h7, 1'b0, 1'b0, 1'b1, e_halt,   "halt");
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, e_halt,   "halt_stays");

    // ADD with three wait cycles, then SUB, jumps and NOPs
    cyc(1'b0, 4'h2, 1'b0, 1'b0, 1'b0, E_ZERO,      "reset2");
    cyc(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, E_ZERO,      "idle2");
    cyc(1'b1, 4'h2, 1'b0, 1'b0, 1'b1, e_f_ok,      "fetch_add");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, e_add_stall, "add_stall");
    cyc(1'b1, 4'h2, 1'b0, 1'b0, 1'b1, e_add_ok,    "add_done");
    cyc(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, e_f_ok,      "fetch_sub");
    cyc(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, e_sub_ok,    "exec_sub");
    cyc(1'b1, 4'h5, 1'b0, 1'b0, 1'b1, e_f_ok,      "fetch_jge0");
    cyc(1'b1, 4'h5, 1'b0, 1'b1, 1'b0, e_jmp,       "jge_n0");
    cyc(1'b1, 4'h5, 1'b1, 1'b0, 1'b1, e_f_ok,      "fetch_jge1");
    cyc(1'b1, 4'h5, 1'b1, 1'b0, 1'b1, E_ZERO,      "jge_n1");
    cyc(1'b1, 4'h6, 1'b0, 1'b1, 1'b1, e_f_ok,      "fetch_jne1");
    cyc(1'b1, 4'h6, 1'b0, 1'b1, 1'b1, E_ZERO,      "jne_z1");
    cyc(1'b1, 4'h6, 1'b1, 1'b0, 1'b1, e_f_ok,      "fetch_jne0");
    cyc(1'b1, 4'h6, 1'b1, 1'b0, 1'b0, e_jmp,       "jne_z0");
    cyc(1'b1, 4'h4, 1'b1, 1'b1, 1'b1, e_f_ok,      "fetch_jmp");
    cyc(1'b1, 4'h4, 1'b1, 1'b1, 1'b0, e_jmp,       "jmp");
    cyc(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, e_f_ok,      "fetch_nop");
    cyc(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, E_ZERO,      "nop_a");
    cyc(1'b1, 4'hF, 1'b0, 1'b0, 1'b1, e_f_ok,      "after_nop_fetch");
    cyc(1'b1, 4'hF, 1'b0, 1'b0, 1'b1, E_ZERO,      "nop_f");

    // Fetch timeout: 15 wait cycles, limit cycle, then HALT with Bus_err
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, E_ZERO,    "reset3");
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, E_ZERO,    "idle3");
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, e_f_stall, "fetch_wait");
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, e_halt_be, "timeout_halt");
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, e_halt_be, "timeout_sticky");

    // mem_ready in the limit cycle completes the fetch; reset clears Bus_err
    cyc(1'b0, 4'h8, 1'b0, 1'b0, 1'b0, E_ZERO,    "reset4_clears_err");
    cyc(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, E_ZERO,    "idle4");
    for (int i = 0; i < 15; i++)
      cyc(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, e_f_stall, "fetch_wait2");
    cyc(1'b1, 4'h8, 1'b0, 1'b0, 1'b1, e_f_ok,    "limit_ready_wins");
    cyc(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, E_ZERO,    "exec_after_limit");

    // Reset during a stalled STA
    cyc(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, e_f_ok,    "fetch_sta2");
    cyc(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, e_sta,     "sta_stall");
    cyc(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, e_sta,     "sta_stall2");
    cyc(1'b0, 4'h1, 1'b0, 1'b0, 1'b0, E_ZERO,    "sta_reset_drop");
    cyc(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, E_ZERO,    "idle5");
    cyc(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, e_f_stall, "fetch5");

    @(posedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
